// File: rtl/tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
//
// Programmable down-counting interval timer driven by the single-cycle `tick`
// pulse from an upstream prescaler. It supports one-shot and periodic modes,
// pause/resume and stop. Each elapsed interval produces a one-cycle `expire`
// pulse and increments a wrapping expiry counter.
//
// Ports:
//   clk      - clock; all state changes on its rising edge
//   rst      - synchronous, active-high reset
//   tick     - single-cycle count enable from the prescaler
//   start    - load load_val/mode and begin counting (also retriggers)
//   stop     - abort the timer and return to IDLE
//   pause    - level; while high, ticks are ignored (RUN -> PAUSE)
//   mode     - 0 = one-shot, 1 = periodic; sampled on an accepted start
//   load_val - interval in ticks; sampled on an accepted start
//   count    - remaining ticks (registered)
//   busy     - high in RUN or PAUSE
//   paused   - high in PAUSE
//   expire   - one-cycle pulse when the interval elapses
//   exp_cnt  - expirations since the last start, wraps modulo 2^EW
//
// Input priority within a cycle: rst > stop > start > pause > tick.
// -----------------------------------------------------------------------------
module tick_timer #(
  parameter int W  = 8,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          mode,
  input  logic [W-1:0]  load_val,
  output logic [W-1:0]  count,
  output logic          busy,
  output logic          paused,
  output logic          expire,
  output logic [EW-1:0] exp_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state_q,   state_d;
  logic [W-1:0]  count_q,   count_d;
  logic [W-1:0]  reload_q,  reload_d;
  logic          mode_q,    mode_d;
  logic [EW-1:0] exp_cnt_q, exp_cnt_d;
  logic          expire_q,  expire_d;
  logic          busy_q,    busy_d;
  logic          paused_q,  paused_d;

  // State register: every flop, synchronous reset to the idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= {W{1'b0}};
      reload_q  <= {W{1'b0}};
      mode_q    <= 1'b0;
      exp_cnt_q <= {EW{1'b0}};
      expire_q  <= 1'b0;
      busy_q    <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      exp_cnt_q <= exp_cnt_d;
      expire_q  <= expire_d;
      busy_q    <= busy_d;
      paused_q  <= paused_d;
    end
  end

  // Next-state logic: resolves stop/start/pause/tick in priority order.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    mode_d    = mode_q;
    exp_cnt_d = exp_cnt_q;
    expire_d  = 1'b0;

    if (stop) begin
      // Stop wins over start even in IDLE; exp_cnt is deliberately held.
      state_d = IDLE;
      count_d = {W{1'b0}};
    end else if (start) begin
      mode_d   = mode;
      reload_d = load_val;
      if (load_val != {W{1'b0}}) begin
        state_d   = RUN;
        count_d   = load_val;
        exp_cnt_d = {EW{1'b0}};
      end else begin
        // A zero interval elapses immediately: single expiry, no RUN phase.
        state_d   = IDLE;
        count_d   = {W{1'b0}};
        expire_d  = 1'b1;
        exp_cnt_d = {{(EW-1){1'b0}}, 1'b1};
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (count_q == {{(W-1){1'b0}}, 1'b1}) begin
              expire_d  = 1'b1;
              exp_cnt_d = exp_cnt_q + {{(EW-1){1'b0}}, 1'b1};
              if (mode_q) begin
                // Reload on the expiring tick so periods abut with no gap.
                count_d = reload_q;
              end else begin
                count_d = {W{1'b0}};
                state_d = IDLE;
              end
            end else if (count_q != {W{1'b0}}) begin
              count_d = count_q - {{(W-1){1'b0}}, 1'b1};
            end else begin
              // Unreachable in RUN; guard against underflow anyway.
              count_d = {W{1'b0}};
              state_d = IDLE;
            end
          end else begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          // Leaving PAUSE consumes the cycle; a same-cycle tick is dropped.
          if (!pause) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = {W{1'b0}};
        end
      endcase
    end

    busy_d   = (state_d != IDLE);
    paused_d = (state_d == PAUSE);
  end

  // Output drive: ports come straight from flops.
  always_comb begin
    count   = count_q;
    busy    = busy_q;
    paused  = paused_q;
    expire  = expire_q;
    exp_cnt = exp_cnt_q;
  end

endmodule
